// File: rtl/mac_pkg.sv
// ============================================================================
// Module : mac_pkg
// Shared types and default sizes for the multiply-accumulate path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int COUNT_DEF  = 4;

endpackage

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module : product_accumulator
// Sums COUNT multiplier products per frame; optional clamp via PRODUCT_ACC_SATURATE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int COUNT  = COUNT_DEF,
    parameter int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_beats,
    output logic              overflow
);

    acc_state_t       state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             ovf, ovf_d;
    logic             out_valid_d;
    logic [ACC_W-1:0] out_sum_d;
    logic [CNT_W-1:0] out_beats_d;
    logic             overflow_d;

    logic             accept;
    logic             release_res;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] frame_acc;
    logic             frame_ovf;
    logic [CNT_W-1:0] frame_cnt;

    assign in_ready    = rst_n && !clr && ((state != DONE) || out_ready);
    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;

    assign prod_ext = ACC_W'(in_prod);
    assign sum_wide = {1'b0, acc} + {1'b0, prod_ext};
    assign carry    = sum_wide[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    // Once clamped, any further non-zero product carries again, so the clamp holds.
    assign acc_sum = carry ? ACC_MAX : sum_wide[ACC_W-1:0];
`else
    assign acc_sum = sum_wide[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        ovf_d       = ovf;
        out_valid_d = out_valid;
        out_sum_d   = out_sum;
        out_beats_d = out_beats;
        overflow_d  = overflow;
        frame_acc   = prod_ext;
        frame_ovf   = 1'b0;
        frame_cnt   = CNT_W'(1);

        if (clr) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (release_res) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            if (accept) begin
                // A beat accepted in IDLE or DONE always opens a fresh frame.
                if (state == ACCUM) begin
                    frame_acc = acc_sum;
                    frame_ovf = ovf | carry;
                    frame_cnt = cnt + CNT_W'(1);
                end
                acc_d = frame_acc;
                ovf_d = frame_ovf;
                cnt_d = frame_cnt;
                if (frame_cnt == CNT_W'(COUNT)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_sum_d   = frame_acc;
                    out_beats_d = CNT_W'(COUNT);
                    overflow_d  = frame_ovf;
                end else begin
                    state_d = ACCUM;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            ovf       <= ovf_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_beats <= out_beats_d;
            overflow  <= overflow_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 combinational array multiplier.
- Consumes its 8-bit products over a valid/ready handshake.
- Sums a fixed-length frame of COUNT products into an ACC_W-bit result.
- Presents the result on a second valid/ready handshake, forming the accumulate half of a multiply-accumulate path.

Parameters:
- PROD_W, 8: width of each incoming product (matches multiplier output P).
- ACC_W, 16: accumulator and result width; must be at least PROD_W.
- COUNT, 4: number of products per frame; must be at least 1.
- CNT_W, $clog2(COUNT+1): width of beat counter and out_beats.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort; returns the block to IDLE.
- in_valid  input  1  in_prod valid.
- in_ready  output  1  block accepts in_prod this cycle.
- in_prod  input  PROD_W  product from the multiplier, unsigned.
- out_valid  output  1  out_sum holds a completed frame.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  ACC_W  frame sum.
- out_beats  output  CNT_W  beats summed (always COUNT when out_valid).
- overflow  output  1  frame sum exceeded 2^ACC_W-1; valid with out_valid.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_beats=0, overflow=0.
  - in_ready goes low while rst_n is low, then follows the rule below.
- Accept rule: in_ready = !clr && (state!=DONE || out_ready). A beat is accepted when in_valid && in_ready. Release rule: result is released when out_valid && out_ready.
- State IDLE:
  - Accepted beat: acc<=in_prod (zero-extended), cnt<=1, ovf<=0.
  - If COUNT==1, go DONE; otherwise go ACCUM.
- State ACCUM:
  - Accepted beat: acc<=acc+in_prod, computed ACC_W+1 bits wide; carry-out sets sticky ovf. cnt<=cnt+1.
  - When the accepted beat makes cnt==COUNT, go DONE.
- DONE is entered on the final accepted beat:
  - Same edge: out_sum<=final sum, out_beats<=COUNT, overflow<=ovf|carry, out_valid<=1.
  - Latency: result visible the cycle after the last beat is accepted.
- State DONE:
  - out_valid held high; out_sum, out_beats and overflow stable until released.
  - Release without an accepted beat: out_valid<=0, go IDLE.
  - Release with an accepted beat in the same cycle: out_valid<=0. That beat starts the next frame as the IDLE rule defines (acc<=in_prod, cnt<=1), so no bubble.
  - If COUNT==1 and both happen in the same cycle: stay DONE, out_valid stays 1, outputs load the new beat.
- Without saturation, the sum wraps modulo 2^ACC_W.
- clr in any state:
  - Next state IDLE; acc, cnt and ovf cleared; out_valid<=0.
  - A pending result is dropped. No beat is accepted that cycle (clr wins over in_valid).
- in_valid low in ACCUM: hold acc and cnt indefinitely; no timeout.
- in_prod is sampled only on accept; its value while in_ready is low is don't-care.

Optional Feature:
- Macro: PRODUCT_ACC_SATURATE_EN.
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the frame. overflow still reports that saturation occurred.
- Undefined: the sum wraps modulo 2^ACC_W; overflow reports the wrap.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package mac_pkg:
  - State enum acc_state_t {IDLE, ACCUM, DONE}.
  - Default constants PROD_W_DEF=8, ACC_W_DEF=16, COUNT_DEF=4.
- One module; no sub-module. The counter and adder are small enough to stay inline. The multiplier is instantiated by the parent, not here.

Test Plan:
- Reset mid-frame: after 2 beats, pulse rst_n low. Outputs return to 0 asynchronously. The next 4 beats 1,2,3,4 give out_sum=10 and out_beats=4.
- Basic frame, out_ready=1: beats 15,15,15,15 (3*5) -> out_valid one cycle after the 4th accept, out_sum=60, overflow=0.
- Back-pressure: out_ready=0 for 5 cycles after DONE. in_ready stays 0, out_sum stays stable at 60. Raising out_ready with in_valid=1 and in_prod=9 releases the result and starts the next frame at acc=9.
- Gapped input: in_valid toggles 1,0,0,1,1,0,1 with products 225,225,225,225 -> out_sum=900 after the 4th accept.
- Overflow with ACC_W=9: 4×255 -> wrap build out_sum=1020 mod 512=508, overflow=1. Saturate build out_sum=511, overflow=1.
- clr abort: clr asserted with in_valid=1 after 3 beats. The beat is not accepted and out_valid stays 0. The next frame 2,2,2,2 gives out_sum=8.
